// File: rtl/bsg_credit_pkg.sv
// Shared types and sizing helpers for the credit token returner.
// Holds the FSM state encoding and the pending-count width helper.
package bsg_credit_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      SEND  = 2'd2
   } credit_state_e;

   // Width of a counter that must represent 0..max_credits inclusive.
   function automatic int credit_count_width(input int max_credits);
      return $clog2(max_credits + 1);
   endfunction

   localparam int credit_count_width_default = credit_count_width(16);

endpackage

// File: rtl/bsg_credit_token_returner.sv
// Folds locally freed credits into decimated tokens for an async credit counter,
// with flush of residual credits and a sticky overflow flag.
module bsg_credit_token_returner
   import bsg_credit_pkg::*;
#(
   parameter int decimation_p  = 4,
   parameter int max_credits_p = 16,
   localparam int cw = credit_count_width(max_credits_p)
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          credit_i,
   input  logic          ready_i,
   input  logic          flush_i,
   output logic          token_o,
   output logic [cw-1:0] count_o,
   output logic          overflow_o
);

   if (decimation_p < 1 || decimation_p > max_credits_p) begin : g_param_check
      $error("bsg_credit_token_returner: need 1 <= decimation_p <= max_credits_p");
   end

   localparam logic [cw-1:0] dec_val = cw'(decimation_p);
   localparam logic [cw-1:0] max_val = cw'(max_credits_p);

   credit_state_e state_reg, state_next;
   logic [cw-1:0] cnt_reg, cnt_next;
   logic          flush_pending_reg, flush_pending_next;
   logic          overflow_reg, overflow_next;
   logic          handshake;
   logic [cw-1:0] taken;
   logic [cw-1:0] drained;

   always_comb begin
      handshake          = 1'b0;
      taken              = '0;
      drained            = cnt_reg;
      cnt_next           = cnt_reg;
      overflow_next      = overflow_reg;
      flush_pending_next = flush_pending_reg;
      state_next         = state_reg;

      handshake = (state_reg == SEND) && ready_i;
      if (handshake) begin
         taken = (cnt_reg < dec_val) ? cnt_reg : dec_val;
      end
      drained  = cnt_reg - taken;
      cnt_next = drained;

      // A credit only saturates when nothing left the counter this cycle.
      if (credit_i) begin
         if (drained == max_val) begin
            overflow_next = 1'b1;
         end else begin
            cnt_next = drained + 1'b1;
         end
      end

      // The flush request lives until the counter is fully drained.
      flush_pending_next = (flush_pending_reg || (flush_i && ((cnt_reg != '0) || credit_i)))
                           && (cnt_next != '0);

      if (cnt_next == '0) begin
         state_next = IDLE;
      end else if ((cnt_next >= dec_val) || flush_pending_next) begin
         state_next = SEND;
      end else begin
         state_next = ACCUM;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_reg         <= IDLE;
         cnt_reg           <= '0;
         flush_pending_reg <= 1'b0;
         overflow_reg      <= 1'b0;
      end else begin
         state_reg         <= state_next;
         cnt_reg           <= cnt_next;
         flush_pending_reg <= flush_pending_next;
         overflow_reg      <= overflow_next;
      end
   end

   assign token_o    = (state_reg == SEND);
   assign count_o    = cnt_reg;
   assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_bsg_credit_token_returner.sv
// Self-checking bench for bsg_credit_token_returner (decimation 4, capacity 16):
// directed table, multi-cycle corner sequences and randomized traffic against a reference model.
module tb_bsg_credit_token_returner;

   localparam int D   = 4;
   localparam int MAX = 16;
   localparam int CW  = $clog2(MAX + 1);

   logic          clk = 1'b0;
   logic          reset_i = 1'b1;
   logic          credit_i = 1'b0;
   logic          ready_i = 1'b0;
   logic          flush_i = 1'b0;
   logic          token_o;
   logic [CW-1:0] count_o;
   logic          overflow_o;

   bsg_credit_token_returner #(
      .decimation_p (D),
      .max_credits_p(MAX)
   ) dut (
      .clk_i     (clk),
      .reset_i   (reset_i),
      .credit_i  (credit_i),
      .ready_i   (ready_i),
      .flush_i   (flush_i),
      .token_o   (token_o),
      .count_o   (count_o),
      .overflow_o(overflow_o)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // Reference model: pending credits, outstanding flush request, sticky error, offered token.
   int m_pending = 0;
   bit m_flush   = 0;
   bit m_ovf     = 0;
   bit m_tok     = 0;

   typedef struct {
      logic credit;
      logic ready;
      logic flush;
      logic tok;
      int   cnt;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_pending = 0;
      m_flush   = 0;
      m_ovf     = 0;
      m_tok     = 0;
   endtask

   task automatic model_step(input bit c, input bit r, input bit f);
      int sent;
      bit want_flush;
      sent = 0;
      if (m_tok && r) sent = (m_pending < D) ? m_pending : D;
      want_flush = m_flush || (f && (m_pending > 0 || c));
      m_pending = m_pending - sent + (c ? 1 : 0);
      if (m_pending > MAX) begin
         m_pending = MAX;
         m_ovf = 1;
      end
      if (m_pending == 0) want_flush = 0;
      m_flush = want_flush;
      m_tok = (m_pending >= D) || (m_flush && m_pending > 0);
   endtask

   // Called #1 after a rising edge; applies inputs across one edge and checks against the model.
   task automatic cycle(input bit c, input bit r, input bit f);
      credit_i = c;
      ready_i  = r;
      flush_i  = f;
      @(posedge clk);
      model_step(c, r, f);
      #1;
      cyc++;
      $display("cyc %0d: credit=%0b ready=%0b flush=%0b -> token=%0b count=%0d overflow=%0b",
               cyc, c, r, f, token_o, count_o, overflow_o);
      check("token_vs_model", int'(token_o), int'(m_tok));
      check("count_vs_model", int'(count_o), m_pending);
      check("overflow_vs_model", int'(overflow_o), int'(m_ovf));
   endtask

   // Asserts reset between edges, checks the asynchronous clear, releases after one edge.
   task automatic do_reset();
      credit_i = 1'b0;
      flush_i  = 1'b0;
      reset_i  = 1'b1;
      #2;
      check("async_reset_token", int'(token_o), 0);
      check("async_reset_count", int'(count_o), 0);
      check("async_reset_overflow", int'(overflow_o), 0);
      @(posedge clk);
      #1;
      reset_i = 1'b0;
      model_reset();
      $display("reset applied and released");
   endtask

   initial begin
      int toks;
      int maxc;

      vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 0};
      vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1};
      vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1};
      vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 0};
      vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 0};
      vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 1};
      vecs[18] = '{1'b1, 1'b0, 1'b1, 1'b1, 2};
      vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 0};

      @(posedge clk);
      #1;
      do_reset();

      // Directed table: decimation, partial flush, held token, ignored flush.
      for (int i = 0; i < 20; i++) begin
         cycle(vecs[i].credit, vecs[i].ready, vecs[i].flush);
         check($sformatf("table%0d_token", i), int'(token_o), int'(vecs[i].tok));
         check($sformatf("table%0d_count", i), int'(count_o), vecs[i].cnt);
         check($sformatf("table%0d_overflow", i), int'(overflow_o), 0);
      end

      // Nine credits while blocked, then back-to-back drain.
      do_reset();
      repeat (9) cycle(1'b1, 1'b0, 1'b0);
      check("b2b_held_count", int'(count_o), 9);
      check("b2b_held_token", int'(token_o), 1);
      cycle(1'b0, 1'b1, 1'b0);
      check("b2b_first_token", int'(token_o), 1);
      check("b2b_first_count", int'(count_o), 5);
      cycle(1'b0, 1'b1, 1'b0);
      check("b2b_second_token", int'(token_o), 0);
      check("b2b_second_count", int'(count_o), 1);

      // Continuous credits with an always-ready sink.
      do_reset();
      toks = 0;
      maxc = 0;
      repeat (40) begin
         cycle(1'b1, 1'b1, 1'b0);
         toks += int'(token_o);
         if (int'(count_o) > maxc) maxc = int'(count_o);
      end
      check("stream_token_count", toks, 10);
      check("stream_max_count", maxc, 4);

      // Overflow at capacity is sticky until reset.
      do_reset();
      repeat (17) cycle(1'b1, 1'b0, 1'b0);
      check("sat_count", int'(count_o), 16);
      check("sat_overflow", int'(overflow_o), 1);
      repeat (3) cycle(1'b0, 1'b1, 1'b0);
      check("sat_overflow_sticky", int'(overflow_o), 1);
      check("sat_drained_count", int'(count_o), 4);
      do_reset();

      // Reset while a token is offered to a stalled sink.
      repeat (5) cycle(1'b1, 1'b0, 1'b0);
      check("midrst_token_before", int'(token_o), 1);
      ready_i = 1'b1;
      do_reset();
      repeat (3) begin
         cycle(1'b0, 1'b1, 1'b0);
         check("midrst_token_after", int'(token_o), 0);
         check("midrst_count_after", int'(count_o), 0);
      end

      // Randomized traffic: a free-flowing phase and a mostly blocked phase.
      do_reset();
      repeat (500) cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
                         $urandom_range(0, 99) < 5);
      repeat (500) cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 10,
                         $urandom_range(0, 99) < 8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bsg_credit_token_returner.md
BSG_CREDIT_TOKEN_RETURNER -- requirements
Module: bsg_credit_token_returner

Interface
REQ-001 The block SHALL have parameter decimation_p, default 4: credits folded into one returned token (1..max_credits_p).
REQ-002 The block SHALL have parameter max_credits_p, default 16: pending-credit capacity (>= decimation_p).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port credit_i, input, 1 bit: one credit freed by the local consumer this cycle.
REQ-006 The block SHALL have port ready_i, input, 1 bit: the token sink (the writer side of the async credit counter) accepts a token this cycle.
REQ-007 The block SHALL have port flush_i, input, 1 bit: request to return the residual credit count at once.
REQ-008 The block SHALL have port token_o, input-side pulse source, output, 1 bit: token valid; one token is transferred per cycle with token_o & ready_i.
REQ-009 The block SHALL have port count_o, output, $clog2(max_credits_p+1) bits: current pending-credit count.
REQ-010 The block SHALL have port overflow_o, output, 1 bit: sticky error flag for a credit lost at capacity.

Function
REQ-011 The block SHALL hold a pending counter cnt of width $clog2(max_credits_p+1); count_o = cnt.
REQ-012 The block SHALL implement a 3-state FSM: IDLE (cnt==0), ACCUM (0<cnt<decimation_p and no flush pending), SEND (cnt>=decimation_p, or flush pending with cnt>0).
REQ-013 token_o SHALL be 1 exactly in state SEND and SHALL be driven from registers only, with no combinational path from any input.
REQ-014 The latency SHALL be 1 cycle: a credit_i edge that raises cnt to decimation_p makes token_o high in the next cycle.
REQ-015 On handshake (token_o & ready_i), cnt SHALL decrease by min(cnt, decimation_p).
REQ-016 When credit_i and a handshake occur in the same cycle, next cnt SHALL be cnt + 1 - min(cnt, decimation_p).
REQ-017 token_o SHALL remain asserted while ready_i is low; it is never withdrawn before a handshake, except by reset.
REQ-018 flush_i SHALL set a flush_pending flag when cnt>0 or credit_i is high; the flag clears on the handshake that drains cnt to 0 (partial token of size cnt < decimation_p permitted).
REQ-019 flush_i with cnt==0 and credit_i low SHALL be ignored.
REQ-020 When credit_i arrives with cnt==max_credits_p and no handshake occurs that cycle, cnt SHALL saturate and overflow_o SHALL set and stay set until reset.
REQ-021 Arithmetic SHALL be unsigned and never wrap; cnt SHALL stay in 0..max_credits_p.
REQ-022 Back-to-back tokens SHALL be supported: if cnt >= 2*decimation_p, token_o SHALL stay high across consecutive handshakes.

Reset
REQ-023 While reset_i=1, cnt=0, state=IDLE, flush_pending=0, overflow_o=0, token_o=0, count_o=0, all asynchronously.
REQ-024 A reset asserted mid-operation SHALL discard pending credits and any offered token; no token SHALL be emitted in the cycle reset deasserts.

Structure
REQ-025 The FSM state enum (IDLE/ACCUM/SEND) SHALL live in the shared package bsg_credit_pkg, together with the count-width helper constant.
REQ-026 The block SHALL be a single module with no sub-modules; the FSM and counter SHALL be one always_ff with next-state logic.
REQ-027 Parameter legality (decimation_p>=1, decimation_p<=max_credits_p) SHALL be checked by elaboration-time assertion.

Verification (decimation_p=4, max_credits_p=16)
REQ-028 Apply 4 credit_i pulses with ready_i=1 -> token_o high exactly one cycle after the 4th pulse, then low; count_o returns 0.
REQ-029 Apply 9 credits with ready_i=0, then ready_i=1 -> two consecutive token_o handshakes, count_o=1, token_o low, state ACCUM.
REQ-030 Hold credit_i=1 continuously with ready_i=1 -> one token every 4 cycles, count_o never exceeds 4.
REQ-031 Apply 3 credits, then a 1-cycle flush_i, ready_i=1 -> one partial token next cycle, count_o=0, flush_pending clear.
REQ-032 Apply 17 credits with ready_i=0 -> count_o=16, overflow_o=1 and sticky; assert reset_i -> all outputs 0 asynchronously.
REQ-033 Assert reset_i while token_o=1 and ready_i=0, release it -> token_o=0, count_o=0, no spurious handshake afterwards.
